pwm_mixer_n: RTL

//  N-channel duty-cycle mixer with PWM output. Sums the duty words of the enabled

---
 rtl/pwm_mixer_n.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pwm_mixer_n.sv
// -----------------------------------------------------------------------------
// pwm_mixer_n
//   Mixes the duty words of up to eight waveform generators into a single
//   glitch-free PWM output. Enabled channel duties are summed, scaled
//   according to the mixing mode, and handed to the PWM stage. The PWM stage
//   only picks up a new duty on the last count of a period, so the pulse is
//   never cut short or split.
//
// Parameters
//   NUM_CH  number of input channels (1..8)
//   DUTY_W  duty word width; one PWM period is 2**DUTY_W sysclk cycles
//
// Ports
//   sysclk        in   system clock, all logic on the rising edge
//   reset         in   synchronous active-high reset
//   ch_duty       in   packed channel duties, channel i at [i*DUTY_W +: DUTY_W]
//   ch_en         in   per-channel enable, a disabled channel contributes 0
//   mode          in   0/3 normalise by enabled count, 1 saturate, 2 wrap
//   pulse         out  registered PWM output
//   period_start  out  one-cycle strobe on the first cycle of every period
//   sat_flag      out  high for the whole period whose duty was clipped/wrapped
// -----------------------------------------------------------------------------
module pwm_mixer_n #(
  parameter int NUM_CH = 4,
  parameter int DUTY_W = 6
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic [NUM_CH*DUTY_W-1:0] ch_duty,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [1:0]               mode,
  output logic                     pulse,
  output logic                     period_start,
  output logic                     sat_flag
);

  // Sum width leaves room for every channel at full scale, so it never overflows.
  localparam int SUM_W = DUTY_W + $clog2(NUM_CH);
  localparam int EN_W  = $clog2(NUM_CH + 1);

  localparam logic [SUM_W-1:0]  DUTY_MAX = SUM_W'((1 << DUTY_W) - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = {DUTY_W{1'b1}};

  // Normalising shift = ceil(log2(enabled channels)); 0 or 1 channel needs none.
  function automatic logic [1:0] norm_shift(input logic [3:0] cnt);
    logic [1:0] sh;
    if (cnt <= 4'd1) begin
      sh = 2'd0;
    end else if (cnt == 4'd2) begin
      sh = 2'd1;
    end else if (cnt <= 4'd4) begin
      sh = 2'd2;
    end else begin
      sh = 2'd3;
    end
    return sh;
  endfunction

  logic [SUM_W-1:0]  sum_q,         sum_d;
  logic [EN_W-1:0]   en_cnt_q,      en_cnt_d;
  logic [DUTY_W-1:0] duty_next_q,   duty_next_d;
  logic              clip_next_q,   clip_next_d;
  logic [DUTY_W-1:0] counter_q,     counter_d;
  logic [DUTY_W-1:0] duty_active_q, duty_active_d;
  logic              clip_active_q, clip_active_d;
  logic              pulse_q,       pulse_d;
  logic              period_start_q, period_start_d;
  logic              sat_flag_q,    sat_flag_d;
  logic [SUM_W-1:0]  shifted_s;

  // Stage 1: masked sum of enabled duties and count of enabled channels.
  // Disabled channels are never read, so X on their duty cannot leak in.
  always_comb begin
    sum_d    = {SUM_W{1'b0}};
    en_cnt_d = {EN_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) begin
        sum_d    = sum_d + SUM_W'(ch_duty[i*DUTY_W +: DUTY_W]);
        en_cnt_d = en_cnt_d + EN_W'(1);
      end else begin
        sum_d    = sum_d;
        en_cnt_d = en_cnt_d;
      end
    end
  end

  // Stage 2: scale the sum into a duty word according to the mixing mode.
  always_comb begin
    shifted_s   = sum_q >> norm_shift(4'(en_cnt_q));
    duty_next_d = {DUTY_W{1'b0}};
    clip_next_d = 1'b0;
    case (mode)
      2'd1: begin
        if (sum_q > DUTY_MAX) begin
          duty_next_d = CNT_LAST;
          clip_next_d = 1'b1;
        end else begin
          duty_next_d = sum_q[DUTY_W-1:0];
          clip_next_d = 1'b0;
        end
      end
      2'd2: begin
        duty_next_d = sum_q[DUTY_W-1:0];
        clip_next_d = (sum_q > DUTY_MAX);
      end
      default: begin
        // Modes 0 and 3: normalise, clamping only if the shift was not enough.
        if (shifted_s > DUTY_MAX) begin
          duty_next_d = CNT_LAST;
          clip_next_d = 1'b1;
        end else begin
          duty_next_d = shifted_s[DUTY_W-1:0];
          clip_next_d = 1'b0;
        end
      end
    endcase
  end

  // PWM stage: free-running counter, duty latched only on the final count.
  always_comb begin
    counter_d = counter_q + DUTY_W'(1);
    if (counter_q == CNT_LAST) begin
      duty_active_d = duty_next_q;
      clip_active_d = clip_next_q;
    end else begin
      duty_active_d = duty_active_q;
      clip_active_d = clip_active_q;
    end
    pulse_d        = (counter_q < duty_active_q);
    period_start_d = (counter_q == {DUTY_W{1'b0}});
    sat_flag_d     = clip_active_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sum_q          <= {SUM_W{1'b0}};
      en_cnt_q       <= {EN_W{1'b0}};
      duty_next_q    <= {DUTY_W{1'b0}};
      clip_next_q    <= 1'b0;
      counter_q      <= {DUTY_W{1'b0}};
      duty_active_q  <= {DUTY_W{1'b0}};
      clip_active_q  <= 1'b0;
      pulse_q        <= 1'b0;
      period_start_q <= 1'b0;
      sat_flag_q     <= 1'b0;
    end else begin
      sum_q          <= sum_d;
      en_cnt_q       <= en_cnt_d;
      duty_next_q    <= duty_next_d;
      clip_next_q    <= clip_next_d;
      counter_q      <= counter_d;
      duty_active_q  <= duty_active_d;
      clip_active_q  <= clip_active_d;
      pulse_q        <= pulse_d;
      period_start_q <= period_start_d;
      sat_flag_q     <= sat_flag_d;
    end
  end

  assign pulse        = pulse_q;
  assign period_start = period_start_q;
  assign sat_flag     = sat_flag_q;

endmodule
